// File: rtl/j1.sv
// j1 -- single-cycle 16-bit stack CPU core.
//
// Every instruction completes in one clock. The code memory is synchronous:
// code_addr carries the next PC combinationally so that the word arriving on
// insn in the following cycle is the instruction at the new PC.
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous, active-low
//   insn       instruction word = mem[code_addr] from the previous cycle
//   code_addr  next-PC word address for the code memory
//   mem_addr   data-memory address (current T)
//   mem_wr     data-memory write strobe (N -> [T])
//   dout       data-memory write data (current N)
//   din        data-memory read data = mem[mem_addr] one clock earlier
//
// Memory handshake: there is no valid/ready pair. The code port is a
// fixed one-cycle-latency read. A data write happens on the rising edge
// that ends a cycle in which mem_wr is high; a data read is op 12 taking
// din, which reflects the address T held during the previous cycle.

module j1 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] insn,
  output logic [12:0] code_addr,
  output logic [15:0] mem_addr,
  output logic        mem_wr,
  output logic [15:0] dout,
  input  logic [15:0] din
);

  // Architectural state
  logic [12:0] pc;
  logic [15:0] t;
  logic [3:0]  dsp;
  logic [3:0]  rsp;
  logic [15:0] dstack [16];
  logic [15:0] rstack [16];

  // Next-state values
  logic [12:0] pc_n;
  logic [15:0] t_n;
  logic [3:0]  dsp_n;
  logic [3:0]  rsp_n;
  logic        dstk_we;
  logic        rstk_we;
  logic [15:0] rstk_wd;
  logic        store;

  logic [15:0] n;
  logic [15:0] r;
  logic [15:0] alu;
  logic [12:0] pc_plus1;

  // Instruction fields
  logic [12:0] target;
  logic [3:0]  alu_op;
  logic [2:0]  alu_func;
  logic [1:0]  rsp_delta;
  logic [1:0]  dsp_delta;
  logic        ret_bit;

  // insn[7] carries no meaning for the ALU format.
  logic unused_insn7;
  assign unused_insn7 = insn[7];

  assign target    = insn[12:0];
  assign ret_bit   = insn[12];
  assign alu_op    = insn[11:8];
  assign alu_func  = insn[6:4];
  assign rsp_delta = insn[3:2];
  assign dsp_delta = insn[1:0];

  assign n        = dstack[dsp];
  assign r        = rstack[rsp];
  assign pc_plus1 = pc + 13'd1;

  // ALU result for the 011 instruction class
  always_comb begin
    alu = t;
    case (alu_op)
      4'd0:    alu = t;
      4'd1:    alu = n;
      4'd2:    alu = t + n;
      4'd3:    alu = t & n;
      4'd4:    alu = t | n;
      4'd5:    alu = t ^ n;
      4'd6:    alu = ~t;
      4'd7:    alu = (n == t) ? 16'hffff : 16'h0000;
      4'd8:    alu = ($signed(n) < $signed(t)) ? 16'hffff : 16'h0000;
      4'd9:    alu = n >> t[3:0];
      4'd10:   alu = t - 16'd1;
      4'd11:   alu = r;
      4'd12:   alu = din;
      4'd13:   alu = n << t[3:0];
      4'd14:   alu = {4'b0000, rsp, 4'b0000, dsp};
      4'd15:   alu = (n < t) ? 16'hffff : 16'h0000;
      default: alu = t;
    endcase
  end

  // Instruction decode: next PC, next T, stack pointer moves and writes
  always_comb begin
    pc_n    = pc_plus1;
    t_n     = t;
    dsp_n   = dsp;
    rsp_n   = rsp;
    dstk_we = 1'b0;
    rstk_we = 1'b0;
    rstk_wd = t;
    store   = 1'b0;
    if (insn[15]) begin
      // literal push
      t_n     = {1'b0, insn[14:0]};
      dsp_n   = dsp + 4'd1;
      dstk_we = 1'b1;
    end else begin
      case (insn[14:13])
        2'b00: pc_n = target;
        2'b01: begin
          // conditional jump always consumes T
          pc_n  = (t == 16'd0) ? target : pc_plus1;
          t_n   = n;
          dsp_n = dsp - 4'd1;
        end
        2'b10: begin
          // return address is stored as a byte address
          pc_n    = target;
          rsp_n   = rsp + 4'd1;
          rstk_we = 1'b1;
          rstk_wd = {2'b00, pc_plus1, 1'b0};
        end
        default: begin
          t_n     = alu;
          dsp_n   = dsp + {{2{dsp_delta[1]}}, dsp_delta};
          rsp_n   = rsp + {{2{rsp_delta[1]}}, rsp_delta};
          // a +1 push always stores old T, so T->N is implied by it
          dstk_we = (dsp_delta == 2'b01) || (alu_func == 3'd1);
          rstk_we = (rsp_delta == 2'b01) || (alu_func == 3'd2);
          store   = (alu_func == 3'd3);
          // R is read at the pre-update rsp
          if (ret_bit) pc_n = r[13:1];
        end
      endcase
    end
  end

  // Reset gates the outward strobes immediately so an aborted store never
  // reaches memory and the code port fetches address 0.
  assign code_addr = reset ? pc_n : 13'd0;
  assign mem_wr    = reset & store;
  assign mem_addr  = t;
  assign dout      = n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= 13'd0;
      t   <= 16'd0;
      dsp <= 4'd0;
      rsp <= 4'd0;
    end else begin
      pc  <= pc_n;
      t   <= t_n;
      dsp <= dsp_n;
      rsp <= rsp_n;
    end
  end

  // Stack RAMs are not cleared by reset; pointers wrap silently.
  always_ff @(posedge clk) begin
    if (dstk_we) dstack[dsp_n] <= t;
    if (rstk_we) rstack[rsp_n] <= rstk_wd;
  end

endmodule

// File: tb/tb_j1.sv
// tb_j1 -- self-checking bench for the j1 core.
// Models a synchronous code memory and a one-cycle-latency data memory,
// loads short programs, and scores the T trace (visible on mem_addr) plus
// targeted checks of code_addr, dout and mem_wr.

module tb_j1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] insn = 16'h0000;
  logic [12:0] code_addr;
  logic [15:0] mem_addr;
  logic        mem_wr;
  logic [15:0] dout;
  logic [15:0] din = 16'h0000;

  logic [15:0] code_mem [8192];
  logic [15:0] data_mem [65536];

  logic [15:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] alu_ops [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd10, 4'd13, 4'd15};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  j1 dut (
    .clk       (clk),
    .reset     (reset),
    .insn      (insn),
    .code_addr (code_addr),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .dout      (dout),
    .din       (din)
  );

  // memory models
  always @(posedge clk) begin
    insn <= code_mem[code_addr];
    din  <= data_mem[mem_addr];
    if (mem_wr) data_mem[mem_addr] <= dout;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_code();
    for (int i = 0; i < 8192; i++) code_mem[i] = 16'h0000;
  endtask

  // leaves the bench at a falling edge with reset just released
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [15:0] alu_model(input logic [3:0] op,
                                            input logic [15:0] nv,
                                            input logic [15:0] tv);
    case (op)
      4'd1:    return nv;
      4'd2:    return nv + tv;
      4'd3:    return nv & tv;
      4'd4:    return nv | tv;
      4'd5:    return nv ^ tv;
      4'd6:    return ~tv;
      4'd7:    return (nv == tv) ? 16'hffff : 16'h0000;
      4'd8:    return ($signed(nv) < $signed(tv)) ? 16'hffff : 16'h0000;
      4'd9:    return nv >> tv[3:0];
      4'd10:   return tv - 16'd1;
      4'd13:   return nv << tv[3:0];
      4'd15:   return (nv < tv) ? 16'hffff : 16'h0000;
      default: return tv;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] e;
    clear_code();
    code_mem[0] = 16'h8009;   // lit 9
    code_mem[1] = 16'h6030;   // N -> [T]
    code_mem[2] = 16'h0001;   // jmp 1
    data_mem[9] = 16'habcd;
    exp_q.push_back(16'h0009);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (code_addr !== 13'd0) $display("FAIL rst_code_addr: got %h expected 0000", code_addr);
      else n_pass++;
      n_checks++;
      if (mem_wr !== 1'b0) $display("FAIL rst_mem_wr: got %b expected 0", mem_wr);
      else n_pass++;
      n_checks++;
      if (mem_addr !== 16'h0000) $display("FAIL rst_t: got %h expected 0000", mem_addr);
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (code_addr !== 13'd1) $display("FAIL first_fetch: code_addr %h expected 0001", code_addr);
    else n_pass++;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (mem_addr !== e) $display("FAIL first_insn_t: got %h expected %h", mem_addr, e);
    else n_pass++;
    n_checks++;
    if (mem_wr !== 1'b1) $display("FAIL store_pending: mem_wr %b expected 1", mem_wr);
    else n_pass++;
    // abort the store in flight
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (mem_wr !== 1'b0) $display("FAIL abort_mem_wr: got %b expected 0", mem_wr);
    else n_pass++;
    n_checks++;
    if (code_addr !== 13'd0) $display("FAIL abort_code_addr: got %h expected 0000", code_addr);
    else n_pass++;
    n_checks++;
    if (mem_addr !== 16'h0000) $display("FAIL abort_t: got %h expected 0000", mem_addr);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (data_mem[9] !== 16'habcd) $display("FAIL abort_no_write: mem[9] %h expected abcd", data_mem[9]);
    else n_pass++;
  endtask

  task automatic test_alu_add();
    logic [15:0] e;
    int n;
    clear_code();
    code_mem[0] = 16'h8005;
    code_mem[1] = 16'h8003;
    code_mem[2] = 16'h6203;   // T+N, dsp -1
    code_mem[3] = 16'h0003;   // jmp 3
    exp_q.push_back(16'h0005);
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0008);
    exp_q.push_back(16'h0008);
    n = exp_q.size();
    do_reset();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (mem_addr !== e) $display("FAIL add_t[%0d]: got %h expected %h", c, mem_addr, e);
      else n_pass++;
      if (c == 3) begin
        n_checks++;
        if (code_addr !== 13'd3) $display("FAIL add_pc: code_addr %h expected 0003", code_addr);
        else n_pass++;
        n_checks++;
        if (dout !== 16'h0000) $display("FAIL add_n: dout %h expected 0000", dout);
        else n_pass++;
      end
    end
  endtask

  task automatic test_call_return();
    logic [15:0] e;
    int n;
    clear_code();
    code_mem[0]     = 16'h0002;   // jmp 2
    code_mem[2]     = 16'h4010;   // call 0x10
    code_mem[16'h10] = 16'h6B01;  // T=R, push
    code_mem[16'h11] = 16'h700C;  // return
    code_mem[3]     = 16'h6E00;   // T=depth
    code_mem[4]     = 16'h0004;   // jmp 4
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0006);
    exp_q.push_back(16'h0006);
    exp_q.push_back(16'h0001);
    n = exp_q.size();
    do_reset();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (mem_addr !== e) $display("FAIL call_t[%0d]: got %h expected %h", c, mem_addr, e);
      else n_pass++;
      if (c == 2) begin
        n_checks++;
        if (code_addr !== 13'h11) $display("FAIL call_target: code_addr %h expected 0011", code_addr);
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (code_addr !== 13'd4) $display("FAIL ret_pc: code_addr %h expected 0004", code_addr);
        else n_pass++;
      end
    end
  endtask

  task automatic test_cond_jump();
    logic [15:0] e;
    int n;
    for (int run = 0; run < 2; run++) begin
      clear_code();
      code_mem[0]     = 16'h8007;
      code_mem[1]     = (run == 0) ? 16'h8000 : 16'h8001;
      code_mem[2]     = 16'h2020;   // jz 0x20
      code_mem[3]     = 16'h6E00;
      code_mem[4]     = 16'h0004;
      code_mem[16'h20] = 16'h6E00;
      code_mem[16'h21] = 16'h0021;
      exp_q.push_back(16'h0007);
      exp_q.push_back((run == 0) ? 16'h0000 : 16'h0001);
      exp_q.push_back(16'h0007);
      exp_q.push_back(16'h0001);
      n = exp_q.size();
      do_reset();
      for (int c = 1; c <= n; c++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (mem_addr !== e) $display("FAIL cjmp%0d_t[%0d]: got %h expected %h", run, c, mem_addr, e);
        else n_pass++;
        if (c == 3) begin
          n_checks++;
          if (code_addr !== ((run == 0) ? 13'h21 : 13'h4))
            $display("FAIL cjmp%0d_pc: code_addr %h expected %h", run, code_addr,
                     (run == 0) ? 13'h21 : 13'h4);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_store();
    logic [15:0] e;
    int n;
    clear_code();
    data_mem[16'h0100] = 16'h0000;
    code_mem[0] = 16'h9234;   // lit 0x1234
    code_mem[1] = 16'h8100;   // lit 0x0100
    code_mem[2] = 16'h6033;   // N -> [T], dsp -1
    code_mem[3] = 16'h6000;   // nop
    code_mem[4] = 16'h6C00;   // T = [T]
    code_mem[5] = 16'h0005;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h1234);
    n = exp_q.size();
    do_reset();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (mem_addr !== e) $display("FAIL store_t[%0d]: got %h expected %h", c, mem_addr, e);
      else n_pass++;
      if (c == 2) begin
        n_checks++;
        if (mem_wr !== 1'b1) $display("FAIL store_wr: got %b expected 1", mem_wr);
        else n_pass++;
        n_checks++;
        if (dout !== 16'h1234) $display("FAIL store_dout: got %h expected 1234", dout);
        else n_pass++;
      end
      if (c == 3) begin
        n_checks++;
        if (mem_wr !== 1'b0) $display("FAIL store_one_cycle: mem_wr %b expected 0", mem_wr);
        else n_pass++;
      end
    end
    n_checks++;
    if (data_mem[16'h0100] !== 16'h1234)
      $display("FAIL store_mem: mem[0100] %h expected 1234", data_mem[16'h0100]);
    else n_pass++;
  endtask

  task automatic test_func_moves();
    logic [15:0] e;
    int n;
    clear_code();
    code_mem[0] = 16'h8005;
    code_mem[1] = 16'h8009;
    code_mem[2] = 16'h6110;   // T=N, T->N (swap)
    code_mem[3] = 16'h6020;   // T->R, no rsp move
    code_mem[4] = 16'h8000;
    code_mem[5] = 16'h6B00;   // T=R
    code_mem[6] = 16'h0006;
    exp_q.push_back(16'h0005);
    exp_q.push_back(16'h0009);
    exp_q.push_back(16'h0005);
    exp_q.push_back(16'h0005);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0005);
    n = exp_q.size();
    do_reset();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (mem_addr !== e) $display("FAIL func_t[%0d]: got %h expected %h", c, mem_addr, e);
      else n_pass++;
      if (c == 3) begin
        n_checks++;
        if (dout !== 16'h0009) $display("FAIL func_t_to_n: dout %h expected 0009", dout);
        else n_pass++;
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [15:0] e;
    logic [14:0] a;
    logic [14:0] b;
    logic [15:0] av;
    logic [3:0]  op;
    logic        inv;
    int n;
    for (int oi = 0; oi < 12; oi++) begin
      for (int tr = 0; tr < 2; tr++) begin
        op  = alu_ops[oi];
        a   = 15'($urandom_range(0, 32767));
        b   = 15'($urandom_range(0, 32767));
        inv = 1'($urandom_range(0, 1));
        if (tr == 1 && (op == 4'd7 || op == 4'd8 || op == 4'd15)) begin
          inv = 1'b0;
          b   = a;
        end
        av = inv ? ~{1'b0, a} : {1'b0, a};
        clear_code();
        code_mem[0] = {1'b1, a};
        code_mem[1] = inv ? 16'h6600 : 16'h6000;
        code_mem[2] = {1'b1, b};
        code_mem[3] = {4'b0110, op, 8'h03};
        code_mem[4] = 16'h0004;
        exp_q.push_back({1'b0, a});
        exp_q.push_back(av);
        exp_q.push_back({1'b0, b});
        exp_q.push_back(alu_model(op, av, {1'b0, b}));
        n = exp_q.size();
        do_reset();
        for (int c = 1; c <= n; c++) begin
          @(negedge clk);
          e = exp_q.pop_front();
          n_checks++;
          if (mem_addr !== e)
            $display("FAIL alu_op%0d_t[%0d]: got %h expected %h (N=%h T=%h)",
                     op, c, mem_addr, e, av, {1'b0, b});
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_stack_wrap();
    logic [15:0] e;
    int n;
    clear_code();
    for (int i = 0; i < 17; i++) begin
      code_mem[i] = 16'h8000 | 16'(i + 1);
      exp_q.push_back(16'(i + 1));
    end
    code_mem[17] = 16'h6E00;
    code_mem[18] = 16'h0012;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0001);
    n = exp_q.size();
    do_reset();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (mem_addr !== e) $display("FAIL wrap_t[%0d]: got %h expected %h", c, mem_addr, e);
      else n_pass++;
      if (c == 17) begin
        n_checks++;
        if (dout !== 16'h0010) $display("FAIL wrap_overwrite: dout %h expected 0010", dout);
        else n_pass++;
      end
      if (c == 19) begin
        n_checks++;
        if (code_addr !== 13'd18) $display("FAIL wrap_loop_pc: code_addr %h expected 0012", code_addr);
        else n_pass++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    test_reset();
    test_alu_add();
    test_call_return();
    test_cond_jump();
    test_store();
    test_func_moves();
    test_alu_ops();
    test_stack_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
